// File: rtl/bp_me_pkg.sv
// Shared BedRock mem message types and the address-to-L2-slice mapping used by the router and DMA side.
// Only the default processor config is supported; the widths below are that config's.
package bp_me_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int paddr_width_gp     = 40;
  localparam int cce_block_width_gp = 512;
  localparam int lce_id_width_gp    = 4;
  localparam int lce_assoc_gp       = 8;
  localparam int block_offset_gp    = $clog2(cce_block_width_gp/8);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]       lce_id;
    logic [$clog2(lce_assoc_gp)-1:0]  way_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_type_e     msg_type;
    logic [2:0]               size;
    logic [paddr_width_gp-1:0] addr;
    bp_bedrock_mem_payload_s  payload;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    bp_bedrock_mem_header_s        header;
    logic [cce_block_width_gp-1:0] data;
  } bp_bedrock_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_mem_msg_s);

  function automatic logic [paddr_width_gp-1:0] bp_dram_base_addr(input bp_params_e cfg);
    case (cfg)
      default: return 40'h00_8000_0000;
    endcase
  endfunction

  function automatic int bp_me_lg_slices(input int num_slices);
    return (num_slices <= 1) ? 1 : $clog2(num_slices);
  endfunction

  // Up to 8 slices; bits above the real slice count stay zero so callers can truncate.
  function automatic logic [2:0] bp_me_slice_sel(input logic [paddr_width_gp-1:0] addr,
                                                 input logic hash_en,
                                                 input int num_slices,
                                                 input logic [paddr_width_gp-1:0] dram_base);
    logic [2:0] sel;
    int lg;
    sel = '0;
    lg  = (num_slices <= 1) ? 0 : $clog2(num_slices);
    if (addr >= dram_base) begin
      for (int i = 0; i < 3; i++) begin
        if (i < lg) begin
          sel[i] = addr[block_offset_gp+i] ^ (hash_en & addr[block_offset_gp+lg+i]);
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/bp_me_cce_to_cache_slice_order_fifo.sv
// Order FIFO of slice IDs with async active-low reset; head is read straight from storage, zero latency.
// No enqueue while full, even alongside a dequeue; dequeue while empty is ignored.
module bp_me_slice_order_fifo
  #(parameter int width_p = 1
  , parameter int els_p   = 8
  , localparam int ptr_width_lp   = (els_p <= 1) ? 1 : $clog2(els_p)
  , localparam int count_width_lp = $clog2(els_p+1)
  )
  (input  logic                      clk_i
  , input  logic                      reset_n_i
  , input  logic [width_p-1:0]        data_i
  , input  logic                      enq_i
  , input  logic                      deq_i
  , output logic [width_p-1:0]        data_o
  , output logic                      full_o
  , output logic                      empty_o
  , output logic [count_width_lp-1:0] count_o
  );

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;
  logic enq, deq;

  assign full_o  = (count_r == count_width_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign count_o = count_r;
  assign enq     = enq_i & ~full_o;
  assign deq     = deq_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_width_lp'(els_p-1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_width_lp'(els_p-1)) ? '0 : rptr_r + 1'b1;
      if (enq & ~deq)      count_r <= count_r + 1'b1;
      else if (deq & ~enq) count_r <= count_r - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_me_cce_to_cache_slice_router.sv
// Routes one BedRock mem command stream to num_slices_p L2 slices by address and returns responses in command order.
// Zero latency both ways; commands stall on slice backpressure or a full order FIFO. Macro BP_ME_SLICE_ROUTER_XOR_HASH_EN selects XOR slice hashing.
module bp_me_cce_to_cache_slice_router
  import bp_me_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , parameter int num_slices_p  = 2
  , parameter int outstanding_p = 8
  , localparam int cce_mem_msg_width_lp = cce_mem_msg_width_gp
  )
  (input  logic                                         clk_i
  , input  logic                                         reset_n_i
  , input  logic [cce_mem_msg_width_lp-1:0]              mem_cmd_i
  , input  logic                                         mem_cmd_v_i
  , output logic                                         mem_cmd_ready_and_o
  , output logic [cce_mem_msg_width_lp-1:0]              mem_resp_o
  , output logic                                         mem_resp_v_o
  , input  logic                                         mem_resp_yumi_i
  , output logic [num_slices_p*cce_mem_msg_width_lp-1:0] slice_cmd_o
  , output logic [num_slices_p-1:0]                      slice_cmd_v_o
  , input  logic [num_slices_p-1:0]                      slice_cmd_ready_and_i
  , input  logic [num_slices_p*cce_mem_msg_width_lp-1:0] slice_resp_i
  , input  logic [num_slices_p-1:0]                      slice_resp_v_i
  , output logic [num_slices_p-1:0]                      slice_resp_yumi_o
  );

  localparam int lg_slices_lp    = bp_me_lg_slices(num_slices_p);
  localparam int block_offset_lp = block_offset_gp;
  localparam int count_width_lp  = $clog2(outstanding_p+1);
  localparam logic [paddr_width_gp-1:0] dram_base_addr_lp = bp_dram_base_addr(bp_params_p);

`ifdef BP_ME_SLICE_ROUTER_XOR_HASH_EN
  localparam logic hash_en_lp = 1'b1;
`else
  localparam logic hash_en_lp = 1'b0;
`endif

  bp_bedrock_mem_msg_s mem_cmd_cast;
  logic [lg_slices_lp-1:0] sel, head;
  logic order_full, order_empty, cmd_fire;
  logic [count_width_lp-1:0] order_count;
  logic [cce_mem_msg_width_lp-1:0] slice_resp_arr [num_slices_p];

  assign mem_cmd_cast = mem_cmd_i;
  assign sel = lg_slices_lp'(bp_me_slice_sel(mem_cmd_cast.header.addr, hash_en_lp,
                                             num_slices_p, dram_base_addr_lp));
  assign slice_cmd_o = {num_slices_p{mem_cmd_cast}};

  assign mem_cmd_ready_and_o = slice_cmd_ready_and_i[sel] & ~order_full;
  assign cmd_fire            = mem_cmd_v_i & mem_cmd_ready_and_o;

  always_comb begin
    slice_cmd_v_o      = '0;
    slice_cmd_v_o[sel] = mem_cmd_v_i & ~order_full;
  end

  bp_me_slice_order_fifo
   #(.width_p(lg_slices_lp), .els_p(outstanding_p))
   order_fifo
    (.clk_i    (clk_i)
    ,.reset_n_i(reset_n_i)
    ,.data_i   (sel)
    ,.enq_i    (cmd_fire)
    ,.deq_i    (mem_resp_yumi_i)
    ,.data_o   (head)
    ,.full_o   (order_full)
    ,.empty_o  (order_empty)
    ,.count_o  (order_count)
    );

  for (genvar i = 0; i < num_slices_p; i++) begin : g_resp
    assign slice_resp_arr[i] = slice_resp_i[i*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
  end

  // Only the head slice may present upstream; every other slice's response is held.
  assign mem_resp_v_o = ~order_empty & slice_resp_v_i[head];
  assign mem_resp_o   = slice_resp_arr[head];

  always_comb begin
    slice_resp_yumi_o       = '0;
    slice_resp_yumi_o[head] = mem_resp_yumi_i & ~order_empty;
  end

`ifndef SYNTHESIS
  resp_while_empty_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    order_empty |-> (slice_resp_v_i == '0));
  yumi_without_v_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_resp_yumi_i |-> mem_resp_v_o);
  count_bound_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    order_count <= count_width_lp'(outstanding_p));
`endif

endmodule
